// File: rtl/img_pos_pkg.sv
// Shared widths, slot record and helpers for image_slot_mapper.
// slot_t is the default-width slot; the top builds its own from its parameters.
package img_pos_pkg;

    localparam int N_SLOTS_D    = 8;
    localparam int QH_W_D       = 5;
    localparam int QV_W_D       = 10;
    localparam int TILE_LOG2_D  = 5;
    localparam int IMG_W_D      = 4;
    localparam int BLINK_LOG2_D = 5;
    localparam int ROW_W_D      = QV_W_D - TILE_LOG2_D;

    localparam int BLANK_ADDR = 0;

    typedef struct packed {
        logic [ROW_W_D-1:0] row;
        logic [QH_W_D-1:0]  col;
        logic [ROW_W_D-1:0] hgt;
        logic [QH_W_D-1:0]  wid;
        logic [IMG_W_D-1:0] img;
        logic               en;
        logic               blink;
    } slot_t;

    function automatic int addr_width(input int img_w, input int tile_log2);
        return img_w + tile_log2;
    endfunction

endpackage

// File: rtl/img_slot_cmp.sv
// One slot's visibility and rectangle match against a tile (row, Qh).
// Ports: i_slot (slot record), i_row, i_qh, i_blink_off -> o_hit.
module img_slot_cmp
    import img_pos_pkg::*;
#(
    parameter type T     = slot_t,
    parameter int  ROW_W = ROW_W_D,
    parameter int  QH_W  = QH_W_D
) (
    input  T                   i_slot,
    input  logic [ROW_W-1:0]   i_row,
    input  logic [QH_W-1:0]    i_qh,
    input  logic               i_blink_off,
    output logic               o_hit
);

    logic              w_visible;
    logic [ROW_W:0]    w_row_end;
    logic [QH_W:0]     w_col_end;
    logic              w_in_row;
    logic              w_in_col;

    assign w_visible = i_slot.en
                     && (i_slot.img != '0)
                     && (i_slot.hgt != '0)
                     && (i_slot.wid != '0)
                     && !(i_slot.blink && i_blink_off);

    // One bit wider so slots running off the screen edge clip instead of wrapping.
    assign w_row_end = {1'b0, i_slot.row} + {1'b0, i_slot.hgt};
    assign w_col_end = {1'b0, i_slot.col} + {1'b0, i_slot.wid};

    assign w_in_row = (i_row >= i_slot.row) && ({1'b0, i_row} < w_row_end);
    assign w_in_col = (i_qh >= i_slot.col) && ({1'b0, i_qh} < w_col_end);

    assign o_hit = w_visible && w_in_row && w_in_col;

endmodule

// File: rtl/image_slot_mapper.sv
// Maps tile coordinates to the image ROM address of the top visible slot.
// Ports: reloj/resetM, Qh/Qv/frame_start, cfg_* writes, DIR_IM/hit/hit_slot.
module image_slot_mapper
    import img_pos_pkg::*;
#(
    parameter int N_SLOTS    = N_SLOTS_D,
    parameter int QH_W       = QH_W_D,
    parameter int QV_W       = QV_W_D,
    parameter int TILE_LOG2  = TILE_LOG2_D,
    parameter int IMG_W      = IMG_W_D,
    parameter int BLINK_LOG2 = BLINK_LOG2_D,
    localparam int SLOT_W    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
    localparam int ROW_W     = QV_W - TILE_LOG2,
    localparam int AW        = addr_width(IMG_W, TILE_LOG2)
) (
    input  logic                 reloj,
    input  logic                 resetM,
    input  logic [QH_W-1:0]      Qh,
    input  logic [QV_W-1:0]      Qv,
    input  logic                 frame_start,
    input  logic                 cfg_we,
    input  logic [SLOT_W-1:0]    cfg_slot,
    input  logic [ROW_W-1:0]     cfg_row,
    input  logic [QH_W-1:0]      cfg_col,
    input  logic [ROW_W-1:0]     cfg_hgt,
    input  logic [QH_W-1:0]      cfg_wid,
    input  logic [IMG_W-1:0]     cfg_img,
    input  logic                 cfg_en,
    input  logic                 cfg_blink,
    output logic                 cfg_pending,
    output logic [AW-1:0]        DIR_IM,
    output logic                 hit,
    output logic [SLOT_W-1:0]    hit_slot
);

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [QH_W-1:0]  col;
        logic [ROW_W-1:0] hgt;
        logic [QH_W-1:0]  wid;
        logic [IMG_W-1:0] img;
        logic             en;
        logic             blink;
    } lslot_t;

    lslot_t                r_shadow [N_SLOTS];
    lslot_t                r_active [N_SLOTS];
    logic [N_SLOTS-1:0]    r_pend;
    logic [BLINK_LOG2-1:0] r_frame;

    lslot_t                r_s1_slot [N_SLOTS];
    logic [QH_W-1:0]       r_s1_qh;
    logic [ROW_W-1:0]      r_s1_row;
    logic [TILE_LOG2-1:0]  r_s1_line;
    logic                  r_s1_boff;

    lslot_t                w_new;
    logic [N_SLOTS-1:0]    w_wr_sel;
    logic [N_SLOTS-1:0]    w_hit;
    logic                  w_any;
    logic [SLOT_W-1:0]     w_win;
    logic [IMG_W-1:0]      w_img;

    assign w_new = '{row: cfg_row, col: cfg_col, hgt: cfg_hgt, wid: cfg_wid,
                     img: cfg_img, en: cfg_en, blink: cfg_blink};

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_wr_sel[i] = cfg_we && (int'(cfg_slot) == i);
        end
    end

    assign cfg_pending = |r_pend;

    // Shadow/active slot sets; a write coinciding with frame_start commits at once.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_pend  <= '0;
            r_frame <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (w_wr_sel[i]) begin
                    r_shadow[i] <= w_new;
                end
                if (frame_start) begin
                    if (w_wr_sel[i]) begin
                        r_active[i] <= w_new;
                    end else if (r_pend[i]) begin
                        r_active[i] <= r_shadow[i];
                    end
                    r_pend[i] <= 1'b0;
                end else if (w_wr_sel[i]) begin
                    r_pend[i] <= 1'b1;
                end
            end
            if (frame_start) begin
                r_frame <= r_frame + BLINK_LOG2'(1);
            end
        end
    end

    // Stage 1 snapshots the slot set with the coordinates, so a commit never
    // mixes old and new slot data within one output.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_s1_slot[i] <= '0;
            end
            r_s1_qh   <= '0;
            r_s1_row  <= '0;
            r_s1_line <= '0;
            r_s1_boff <= 1'b0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_s1_slot[i] <= r_active[i];
            end
            r_s1_qh   <= Qh;
            r_s1_row  <= Qv[QV_W-1:TILE_LOG2];
            r_s1_line <= Qv[TILE_LOG2-1:0];
            r_s1_boff <= r_frame[BLINK_LOG2-1];
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_cmp
        img_slot_cmp #(
            .T     (lslot_t),
            .ROW_W (ROW_W),
            .QH_W  (QH_W)
        ) u_cmp (
            .i_slot      (r_s1_slot[g]),
            .i_row       (r_s1_row),
            .i_qh        (r_s1_qh),
            .i_blink_off (r_s1_boff),
            .o_hit       (w_hit[g])
        );
    end

    // Walk from the lowest priority up so the lowest index wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_img = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any = 1'b1;
                w_win = SLOT_W'(i);
                w_img = r_s1_slot[i].img;
            end
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            DIR_IM   <= AW'(BLANK_ADDR);
            hit      <= 1'b0;
            hit_slot <= '0;
        end else begin
            DIR_IM   <= w_any ? {w_img, r_s1_line} : AW'(BLANK_ADDR);
            hit      <= w_any;
            hit_slot <= w_win;
        end
    end

endmodule

// File: tb/tb_image_slot_mapper.sv
// Scoreboard bench for image_slot_mapper.
// Probes push expected results; a negedge monitor pops and compares.
module tb_image_slot_mapper;

    logic       reloj = 1'b0;
    logic       resetM;
    logic [4:0] Qh;
    logic [9:0] Qv;
    logic       frame_start;
    logic       cfg_we;
    logic [2:0] cfg_slot;
    logic [4:0] cfg_row;
    logic [4:0] cfg_col;
    logic [4:0] cfg_hgt;
    logic [4:0] cfg_wid;
    logic [3:0] cfg_img;
    logic       cfg_en;
    logic       cfg_blink;
    logic       cfg_pending;
    logic [8:0] DIR_IM;
    logic       hit;
    logic [2:0] hit_slot;

    always #5 reloj = ~reloj;

    image_slot_mapper dut (
        .reloj       (reloj),
        .resetM      (resetM),
        .Qh          (Qh),
        .Qv          (Qv),
        .frame_start (frame_start),
        .cfg_we      (cfg_we),
        .cfg_slot    (cfg_slot),
        .cfg_row     (cfg_row),
        .cfg_col     (cfg_col),
        .cfg_hgt     (cfg_hgt),
        .cfg_wid     (cfg_wid),
        .cfg_img     (cfg_img),
        .cfg_en      (cfg_en),
        .cfg_blink   (cfg_blink),
        .cfg_pending (cfg_pending),
        .DIR_IM      (DIR_IM),
        .hit         (hit),
        .hit_slot    (hit_slot)
    );

    typedef struct {
        int         due;
        logic [8:0] dir;
        logic       h;
        logic [2:0] s;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   fcount   = 0;

    always @(posedge reloj) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge reloj) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            mon_e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s_missed actual=none required=due@%0d", mon_e.name,
                     mon_e.due);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_dir"}, 32'(DIR_IM), 32'(mon_e.dir));
            chk({mon_e.name, "_hit"}, 32'(hit), 32'(mon_e.h));
            chk({mon_e.name, "_slot"}, 32'(hit_slot), 32'(mon_e.s));
        end
    end

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic probe(input logic [4:0] qh, input logic [9:0] qv,
                         input logic [8:0] dir, input logic h,
                         input logic [2:0] s, input string nm);
        exp_t e;
        Qh     = qh;
        Qv     = qv;
        e.due  = cyc + 2;
        e.dir  = dir;
        e.h    = h;
        e.s    = s;
        e.name = nm;
        sb.push_back(e);
        tick();
    endtask

    task automatic wr(input logic [2:0] slot, input logic [4:0] row,
                      input logic [4:0] col, input logic [4:0] hgt,
                      input logic [4:0] wid, input logic [3:0] img,
                      input logic en, input logic blink, input logic fs);
        cfg_slot    = slot;
        cfg_row     = row;
        cfg_col     = col;
        cfg_hgt     = hgt;
        cfg_wid     = wid;
        cfg_img     = img;
        cfg_en      = en;
        cfg_blink   = blink;
        cfg_we      = 1'b1;
        frame_start = fs;
        tick();
        cfg_we      = 1'b0;
        frame_start = 1'b0;
        if (fs) fcount++;
    endtask

    task automatic commit(input int n);
        frame_start = 1'b1;
        repeat (n) tick();
        frame_start = 1'b0;
        fcount += n;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() > 0 && k < 20) begin
            tick();
            k++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0 pending expectations",
                     sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic vis;
        resetM      = 1'b0;
        Qh          = '0;
        Qv          = '0;
        frame_start = 1'b0;
        cfg_we      = 1'b0;
        cfg_slot    = '0;
        cfg_row     = '0;
        cfg_col     = '0;
        cfg_hgt     = '0;
        cfg_wid     = '0;
        cfg_img     = '0;
        cfg_en      = 1'b0;
        cfg_blink   = 1'b0;
        #1;
        chk("rst_dir", 32'(DIR_IM), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_slot", 32'(hit_slot), 32'd0);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        repeat (3) tick();
        resetM = 1'b1;
        tick();

        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                probe(5'(c), 10'(r * 32 + c), 9'd0, 1'b0, 3'd0, "sweep");
            end
        end
        drain();
        chk("sweep_pending", 32'(cfg_pending), 32'd0);

        wr(3'd2, 5'd3, 5'd4, 5'd1, 5'd1, 4'd3, 1'b1, 1'b0, 1'b0);
        chk("wr_pending", 32'(cfg_pending), 32'd1);
        probe(5'd4, 10'd100, 9'd0, 1'b0, 3'd0, "uncommitted");
        commit(1);
        chk("commit_pending", 32'(cfg_pending), 32'd0);
        probe(5'd4, 10'd100, 9'h064, 1'b1, 3'd2, "s2_hit");
        probe(5'd5, 10'd100, 9'd0, 1'b0, 3'd0, "s2_right");
        probe(5'd3, 10'd100, 9'd0, 1'b0, 3'd0, "s2_left");
        probe(5'd4, 10'd128, 9'd0, 1'b0, 3'd0, "s2_below");
        probe(5'd4, 10'd127, 9'd127, 1'b1, 3'd2, "s2_lastline");

        wr(3'd1, 5'd4, 5'd6, 5'd2, 5'd4, 4'd5, 1'b1, 1'b0, 1'b0);
        wr(3'd4, 5'd5, 5'd8, 5'd1, 5'd1, 4'd6, 1'b1, 1'b0, 1'b0);
        commit(1);
        probe(5'd8, 10'd167, 9'd167, 1'b1, 3'd1, "ovl_s1");
        probe(5'd6, 10'd128, 9'd160, 1'b1, 3'd1, "ovl_s1_corner");
        probe(5'd10, 10'd167, 9'd0, 1'b0, 3'd0, "ovl_outside");
        wr(3'd1, 5'd4, 5'd6, 5'd2, 5'd4, 4'd5, 1'b0, 1'b0, 1'b0);
        probe(5'd8, 10'd167, 9'd167, 1'b1, 3'd1, "ovl_before_commit");
        commit(1);
        probe(5'd8, 10'd167, 9'd199, 1'b1, 3'd4, "ovl_s4");
        probe(5'd6, 10'd128, 9'd0, 1'b0, 3'd0, "ovl_s1_gone");

        wr(3'd3, 5'd0, 5'd0, 5'd1, 5'd1, 4'd2, 1'b1, 1'b0, 1'b1);
        chk("same_edge_pending", 32'(cfg_pending), 32'd0);
        probe(5'd0, 10'd3, 9'd67, 1'b1, 3'd3, "same_edge");

        wr(3'd5, 5'd30, 5'd20, 5'd5, 5'd20, 4'd7, 1'b1, 1'b0, 1'b0);
        commit(1);
        probe(5'd31, 10'd960, 9'd224, 1'b1, 3'd5, "clip_r30");
        probe(5'd20, 10'd1023, 9'd255, 1'b1, 3'd5, "clip_r31");
        probe(5'd20, 10'd20, 9'd0, 1'b0, 3'd0, "clip_row0");
        probe(5'd19, 10'd960, 9'd0, 1'b0, 3'd0, "clip_col19");
        probe(5'd25, 10'd959, 9'd0, 1'b0, 3'd0, "clip_row29");

        wr(3'd6, 5'd10, 5'd10, 5'd1, 5'd1, 4'd9, 1'b1, 1'b1, 1'b0);
        commit(1);
        commit(3);
        for (int f = 0; f < 34; f++) begin
            vis = (fcount % 32) < 16;
            probe(5'd10, 10'd320, vis ? 9'd288 : 9'd0, vis,
                  vis ? 3'd6 : 3'd0, "blink");
            commit(1);
        end
        drain();

        wr(3'd0, 5'd10, 5'd10, 5'd1, 5'd1, 4'd1, 1'b1, 1'b0, 1'b0);
        chk("prerst_pending", 32'(cfg_pending), 32'd1);
        Qh = 5'd10;
        Qv = 10'd320;
        repeat (3) tick();
        chk("prerst_hit", 32'(hit), 32'd1);
        chk("prerst_slot", 32'(hit_slot), 32'd6);
        #2;
        resetM = 1'b0;
        #1;
        chk("async_dir", 32'(DIR_IM), 32'd0);
        chk("async_hit", 32'(hit), 32'd0);
        chk("async_slot", 32'(hit_slot), 32'd0);
        chk("async_pending", 32'(cfg_pending), 32'd0);
        repeat (2) tick();
        resetM = 1'b1;
        fcount = 0;
        tick();
        commit(1);
        chk("post_rst_pending", 32'(cfg_pending), 32'd0);
        probe(5'd10, 10'd320, 9'd0, 1'b0, 3'd0, "post_rst_s0");
        probe(5'd4, 10'd100, 9'd0, 1'b0, 3'd0, "post_rst_s2");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
